// File: rtl/sad_min_select_if.sv
// sad_min_select_if: SAD stream in, best motion vector out.
// master = SAD producer / result consumer, slave = sad_min_select.
interface sad_min_select_if #(
    parameter int XW = 4,
    parameter int YW = 4
);
    logic          start;
    logic          sad_valid;
    logic [11:0]   sad;
    logic [11:0]   thresh;
    logic          busy;
    logic          done;
    logic [11:0]   best_sad;
    logic [XW-1:0] best_x;
    logic [YW-1:0] best_y;
    logic          early;

    modport master (
        output start, sad_valid, sad, thresh,
        input  busy, done, best_sad, best_x, best_y, early
    );

    modport slave (
        input  start, sad_valid, sad, thresh,
        output busy, done, best_sad, best_x, best_y, early
    );
endinterface

// File: rtl/sad_min_select.sv
// sad_min_select: tracks the minimum SAD over a raster-ordered search
// window and publishes its (x, y) index with a one-cycle done pulse.
// Optional feature macro: SAD_EARLY_EXIT_EN (end the window on sad <= thresh).
module sad_min_select #(
    parameter int SEARCH_W = 16,
    parameter int SEARCH_H = 16,
    parameter int XW       = $clog2(SEARCH_W),
    parameter int YW       = $clog2(SEARCH_H)
) (
    input logic             clk,
    input logic             rst,
    sad_min_select_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state, state_nx;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [11:0]   run_min;
    logic [XW-1:0] run_x;
    logic [YW-1:0] run_y;
    logic [11:0]   best_sad_q;
    logic [XW-1:0] best_x_q;
    logic [YW-1:0] best_y_q;

    logic          consume;
    logic          last_cand;
    logic          early_hit;
    logic          finish;
    logic          is_less;
    logic [11:0]   cand_min;
    logic [XW-1:0] cand_x;
    logic [YW-1:0] cand_y;

    // A start in the same cycle takes priority over any candidate.
    assign consume   = (state == SCAN) && bus.sad_valid && !bus.start;
    assign last_cand = (x_cnt == XW'(SEARCH_W - 1)) && (y_cnt == YW'(SEARCH_H - 1));
    assign is_less   = bus.sad < run_min;
    assign cand_min  = is_less ? bus.sad : run_min;
    assign cand_x    = is_less ? x_cnt   : run_x;
    assign cand_y    = is_less ? y_cnt   : run_y;

`ifdef SAD_EARLY_EXIT_EN
    logic early_q;
    assign early_hit = bus.sad <= bus.thresh;
`else
    logic unused_thresh;
    assign unused_thresh = ^bus.thresh;
    assign early_hit     = 1'b0;
`endif

    assign finish = consume && (last_cand || early_hit);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; start from any state (including DONE) enters SCAN.
    always_comb begin
        state_nx = state;
        if (bus.start) begin
            state_nx = SCAN;
        end else begin
            case (state)
                IDLE:    state_nx = IDLE;
                SCAN:    if (finish) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Position counters, running minimum and published result.
    // The result is captured on the consuming edge from the combined compare,
    // so it is already valid in the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            run_min    <= '1;
            run_x      <= '0;
            run_y      <= '0;
            best_sad_q <= '1;
            best_x_q   <= '0;
            best_y_q   <= '0;
        end else if (bus.start) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            run_min <= '1;
            run_x   <= '0;
            run_y   <= '0;
        end else if (consume) begin
            run_min <= cand_min;
            run_x   <= cand_x;
            run_y   <= cand_y;
            if (x_cnt == XW'(SEARCH_W - 1)) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + YW'(1);
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
            if (finish) begin
                best_sad_q <= cand_min;
                best_x_q   <= cand_x;
                best_y_q   <= cand_y;
            end
        end
    end

`ifdef SAD_EARLY_EXIT_EN
    // Early flag: set when the threshold (not the final candidate) ends the window.
    always_ff @(posedge clk) begin
        if (rst)         early_q <= 1'b0;
        else if (finish) early_q <= early_hit && !last_cand;
    end
    assign bus.early = early_q;
`else
    assign bus.early = 1'b0;
`endif

    assign bus.busy     = (state == SCAN);
    assign bus.done     = (state == DONE);
    assign bus.best_sad = best_sad_q;
    assign bus.best_x   = best_x_q;
    assign bus.best_y   = best_y_q;

endmodule

// File: tb/tb_sad_min_select.sv
// tb_sad_min_select: directed vectors for a 4x4 search window.
module tb_sad_min_select;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sad_min_select_if #(.XW(2), .YW(2)) bus ();

    sad_min_select #(.SEARCH_W(4), .SEARCH_H(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    logic busy_at_done = 1'b0;
    int start_cyc = 0;

    // Cycle stamp and done-pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.done === 1'b1) begin
            done_cnt      = done_cnt + 1;
            last_done_cyc = cyc;
            busy_at_done  = bus.busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.start     = 1'b1;
        bus.sad_valid = 1'b0;
        start_cyc     = cyc + 1;
        step();
        bus.start = 1'b0;
    endtask

    // Gap cycles drive sad=1 with valid low: consuming one would corrupt the min.
    task automatic feed(input int vals[16], input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bus.sad_valid = 1'b1;
            bus.sad       = 12'(vals[i]);
            step();
            if (gap > 0) begin
                bus.sad_valid = 1'b0;
                bus.sad       = 12'd1;
                repeat (gap) step();
            end
        end
        bus.sad_valid = 1'b0;
        bus.sad       = 12'd1;
    endtask

    task automatic run_window(input string tag, input int vals[16], input int gap,
                              input int abort_n, input int exp_sad, input int exp_x,
                              input int exp_y, input int exp_early, input int exp_len);
        int base;
        int ones[16];
        foreach (ones[k]) ones[k] = 1;
        base = done_cnt;
        if (abort_n > 0) begin
            start_pulse();
            feed(ones, abort_n, 0);
        end
        start_pulse();
        feed(vals, 16, gap);
        for (int i = 0; i < 40 && done_cnt == base; i++) step();
        step();
        step();
        check({tag, "_done_count"}, 32'(done_cnt - base), 32'd1);
        check({tag, "_latency"}, 32'(last_done_cyc - start_cyc + 1), 32'(exp_len));
        check({tag, "_busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
        check({tag, "_best_sad"}, {20'd0, bus.best_sad}, 32'(exp_sad));
        check({tag, "_best_x"}, {30'd0, bus.best_x}, 32'(exp_x));
        check({tag, "_best_y"}, {30'd0, bus.best_y}, 32'(exp_y));
        check({tag, "_early"}, {31'd0, bus.early}, 32'(exp_early));
        check({tag, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v_main[16] = '{100, 90, 80, 70, 60, 50, 40, 30, 35, 20, 45, 55, 65, 75, 85, 95};
        int v_tie[16]  = '{50, 51, 52, 5, 54, 55, 56, 57, 58, 59, 60, 61, 5, 63, 64, 65};
        int v_last[16] = '{100, 90, 80, 70, 60, 50, 40, 30, 35, 20, 45, 55, 65, 75, 85, 7};
        int v_early[16] = '{40, 39, 38, 37, 6, 30, 31, 32, 33, 34, 2, 35, 36, 41, 42, 43};
        int ones[16];
        int base;
        foreach (ones[k]) ones[k] = 1;

        bus.start     = 1'b0;
        bus.sad_valid = 1'b0;
        bus.sad       = 12'd1;
        bus.thresh    = 12'd0;
        repeat (3) step();
        rst = 1'b0;
        step();

        check("reset_best_sad", {20'd0, bus.best_sad}, 32'hFFF);
        check("reset_best_x", {30'd0, bus.best_x}, 32'd0);
        check("reset_best_y", {30'd0, bus.best_y}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_early", {31'd0, bus.early}, 32'd0);

        // SAD valid in IDLE must be ignored.
        feed(ones, 3, 0);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
        check("idle_done_count", 32'(done_cnt), 32'd0);

        run_window("main", v_main, 0, 0, 20, 1, 2, 0, 18);
        run_window("tie", v_tie, 1, 0, 5, 3, 0, 0, 33);
        run_window("restart", v_last, 0, 7, 7, 3, 3, 0, 18);

        // Reset in the middle of a window.
        base = done_cnt;
        start_pulse();
        check("scan_busy", {31'd0, bus.busy}, 32'd1);
        feed(ones, 10, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_best_sad", {20'd0, bus.best_sad}, 32'hFFF);
        check("midrst_best_x", {30'd0, bus.best_x}, 32'd0);
        check("midrst_best_y", {30'd0, bus.best_y}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        feed(ones, 8, 0);
        repeat (4) step();
        check("midrst_no_done", 32'(done_cnt - base), 32'd0);
        run_window("post_rst", v_main, 0, 0, 20, 1, 2, 0, 18);

        bus.thresh = 12'd8;
`ifdef SAD_EARLY_EXIT_EN
        run_window("early", v_early, 0, 0, 6, 0, 1, 1, 7);
`else
        run_window("early", v_early, 0, 0, 2, 2, 2, 0, 18);
`endif
        bus.thresh = 12'd0;
        run_window("after_early", v_main, 0, 0, 20, 1, 2, 0, 18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sad_min_select.md
# sad_min_select

Motion-vector selection stage placed directly downstream of the 4x4 SAD processing element. It consumes one 12-bit SAD per candidate position, delivered in raster order over the search window. It tracks the running minimum SAD and the (x, y) index of that candidate. After the last candidate it publishes the best motion vector and its SAD with a one-cycle `done` pulse.

## Interface
- `SEARCH_W`, default 16: horizontal candidate count per search window; must be ≥2.
- `SEARCH_H`, default 16: vertical candidate count per search window; must be ≥2.
- `XW`, default `$clog2(SEARCH_W)`: width of x index.
- `YW`, default `$clog2(SEARCH_H)`: width of y index.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high; the only clock/reset pair.
- `start`  in  1  one-cycle pulse; begins a new search window.
- `sad_valid`  in  1  `sad` carries the SAD of the next candidate this cycle.
- `sad`  in  12  candidate SAD (0..4080) from the PE.
- `thresh`  in  12  early-exit threshold; used only with `SAD_EARLY_EXIT_EN`.
- `busy`  out  1  high while a window scan is in progress.
- `done`  out  1  one-cycle pulse; result outputs are valid.
- `best_sad`  out  12  minimum SAD of the last completed window.
- `best_x`  out  XW  column index of the minimum.
- `best_y`  out  YW  row index of the minimum.
- `early`  out  1  last window ended by early exit; always 0 without the macro.

## Operation
- FSM states are IDLE, SCAN and DONE.
- IDLE: `start` causes the following on the next edge:
  - x_cnt=0, y_cnt=0;
  - run_min=12'hFFF, run_x=0, run_y=0;
  - move to SCAN.
- IDLE: `sad_valid` is ignored.
- SCAN: each `sad_valid` cycle consumes one candidate at (x_cnt, y_cnt).
  - If `sad` < run_min (strict), then run_min=`sad`, run_x=x_cnt, run_y=y_cnt.
  - A tie keeps the earlier raster position.
  - x_cnt increments. At SEARCH_W-1, x_cnt wraps to 0 and y_cnt increments.
- The candidate at (SEARCH_W-1, SEARCH_H-1) is the last one. Consuming it moves the FSM to DONE.
  - The comparison for this candidate is included in the result.
- DONE lasts exactly one cycle:
  - latch run_min/run_x/run_y into `best_sad`/`best_x`/`best_y`;
  - assert `done`;
  - return to IDLE.
- Result outputs hold their value until the next DONE.
- `start` during SCAN restarts the scan: counters and running minimum reinitialise and no `done` is issued for the aborted window.
- `start` in the DONE cycle is accepted: the result is still published, and the FSM enters SCAN on the next edge instead of IDLE.
- Gaps in `sad_valid` during SCAN are allowed; counters advance only on valid cycles.
- Values are unsigned. No SAD arithmetic beyond 12-bit compare.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `early`=0;
  - `best_sad`=12'hFFF, `best_x`=0, `best_y`=0;
  - FSM=IDLE.
- `busy` rises in the cycle after `start`. It falls in the cycle `done` is high.
- Latency: `done` is high in the cycle after the edge that consumed the last candidate. The result outputs update on that same edge.
- Minimum window duration is SEARCH_W*SEARCH_H + 2 cycles from `start` to `done`.
- `rst` mid-scan returns to reset values on the next edge. No `done` is issued.

## Configuration
- Macro: `SAD_EARLY_EXIT_EN`.
- Defined:
  - In SCAN, a consumed candidate with `sad` ≤ `thresh` ends the window immediately.
  - That candidate becomes the result (it is necessarily ≤ run_min unless an earlier candidate was already lower; the strict-minimum rule still applies).
  - The FSM moves to DONE and `early`=1 with `done`.
  - Remaining `sad_valid` pulses are ignored until the next `start`.
  - A window completed normally sets `early`=0.
- Undefined: `thresh` is unused, `early` is tied 0, and every window runs to its last candidate.

## Test plan
- SEARCH_W=SEARCH_H=4; after reset, check outputs before any start → `best_sad`=0xFFF, `best_x`=`best_y`=0, `busy`=`done`=0.
- start, 16 consecutive SADs 100,90,…, with 20 at index 9 and everything else ≥30 → `done` on cycle 18 after start; `best_sad`=20, `best_x`=1, `best_y`=2.
- Equal minimum 5 at indices 3 and 12, `sad_valid` toggling every other cycle → `best_x`=3, `best_y`=0; `done` only after the 16th valid.
- start, 7 SADs, start again, then 16 SADs with minimum 7 at index 15 → exactly one `done`; `best_sad`=7, `best_x`=3, `best_y`=3.
- Assert `rst` after 10 SADs → outputs at reset values next cycle; no `done`; a subsequent window completes normally.
- With `SAD_EARLY_EXIT_EN`, `thresh`=8, SAD 6 at index 4 → `done` with `early`=1, `best_sad`=6, `best_x`=0, `best_y`=1; the 11 trailing SADs are ignored.
